instr_fetch_mem: RTL and testbench
==================================

# instr_fetch_mem

Parametrised instruction store for the Pixels Machine sequencer, and the successor to the plain single-port instruction RAM. It has a streaming loader port that auto-increments the write address under a valid/ready handshake, and a fetch port with a one-cycle registered read and an output holding register, so the sequencer can stall. A load state machine keeps fetches out of the RAM while a program is being written.

## Interface
- DATA_WIDTH, 60, instruction word width in bits.
- ADDR_WIDTH, 8, address width; depth is DEPTH = 2**ADDR_WIDTH.
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- ld_start  input  1  one-cycle pulse that starts a load; honoured only in IDLE.
- ld_base  input  ADDR_WIDTH  first write address; sampled with ld_start.
- ld_len  input  ADDR_WIDTH+1  number of words to load; sampled with ld_start.
- ld_valid  input  1  loader word valid.
- ld_data  input  DATA_WIDTH  loader word.
- ld_ready  output  1  loader can accept a word; high only in LOAD.
- ld_done  output  1  one-cycle pulse when the last word has been written.
- busy  output  1  high in LOAD.
- fetch_valid  input  1  fetch request.
- fetch_addr  input  ADDR_WIDTH  fetch address.
- fetch_ready  output  1  fetch request accepted this cycle.
- instr_valid  output  1  instr_data holds a fetched word.
- instr_data  output  DATA_WIDTH  fetched instruction.
- instr_ready  input  1  consumer takes the instr_data word.
- parity_err  output  1  sticky parity error flag; see Configuration.

## Operation
- **State machine:** IDLE, LOAD, DONE.
- **IDLE to LOAD:** on ld_start with ld_len != 0.
  - Latch the write pointer wp = ld_base.
  - Latch the remaining count rc = min(ld_len, DEPTH).
- **ld_len = 0:** ld_start is a no-op; the block stays in IDLE and does not pulse ld_done.
- **ld_start outside IDLE:** ignored.
- **LOAD:** ld_ready = 1.
  - On each cycle with ld_valid && ld_ready: ram[wp] <= ld_data, wp <= wp+1 modulo DEPTH (wraps from DEPTH-1 to 0), rc <= rc-1.
  - When rc reaches 0 after a write, go to DONE.
- **DONE:** ld_done = 1 for exactly one cycle, then return to IDLE.
- **Fetch acceptance:** fetch_ready = (state==IDLE) && !ld_start && (!instr_valid || instr_ready).
  - ld_start has priority over a same-cycle fetch.
  - A write and a read never hit the RAM in the same cycle.
- **Accepted fetch** (fetch_valid && fetch_ready): the address is registered, the RAM word is read, and it is presented on instr_data with instr_valid = 1.
- **Holding behaviour:** while instr_valid && !instr_ready, instr_data and instr_valid hold, and fetch_ready = 0.
- **Draining:** if instr_valid && instr_ready and no new fetch is accepted, instr_valid drops next cycle.
- **During LOAD:** a word already in the holding register stays valid and can still be consumed.
- **Reset values:**
  - State IDLE.
  - ld_ready 0, ld_done 0, busy 0.
  - instr_valid 0, instr_data 0.
  - parity_err 0.
  - wp 0, rc 0.
  - RAM contents are not reset.
- **Reset during LOAD:** the load is aborted with no ld_done pulse; words already written stay in the RAM.

## Timing
- **Fetch latency:** a fetch accepted at edge N gives instr_valid = 1 and instr_data = ram[fetch_addr] after edge N+1.
- **Fetch throughput:** back-to-back fetches run at 1 word/cycle while instr_ready = 1.
- **Load throughput:** 1 word/cycle while ld_valid = 1.
  - A load of L words with no stalls takes 1 (start) + L (LOAD) + 1 (DONE) cycles before fetch_ready can rise again.
- **ld_done timing:** ld_done rises on the cycle after the last write edge.
  - That word is readable by the first fetch accepted after DONE.
- **busy / ld_ready:** both are registered state decodes; they rise the cycle after ld_start.

## Configuration
- **INSTR_MEM_PARITY_EN defined:**
  - The RAM is DATA_WIDTH+1 bits wide; each write stores the even parity (XOR) of ld_data.
  - On each read, the stored parity is checked against the read data as it is loaded into the holding register.
  - On a mismatch, parity_err sets and stays set until rst.
  - A mismatched word is still presented on instr_data.
- **INSTR_MEM_PARITY_EN undefined:** the RAM is DATA_WIDTH bits wide and parity_err is tied to 0.

## Test plan
- **Reset then load:** rst, then ld_start with ld_base=0x10, ld_len=4, words 0xA..0xD streamed with ld_valid always 1 -> busy high for 4 cycles, ld_done pulses once, fetches of 0x10..0x13 return 0xA..0xD each 1 cycle after acceptance.
- **Wrap-around:** ld_base=0xFE, ld_len=3 -> words land at 0xFE, 0xFF and 0x00. Separately, ld_len=300 (clamped to 256) -> ld_done after exactly 256 writes.
- **Loader stall:** ld_valid toggling 1,0,1,0 -> exactly ld_len writes; no write on ld_valid=0 cycles.
- **Consumer stall:** instr_ready=0 for 5 cycles with fetch_valid=1 -> instr_data stable, fetch_ready 0; on release, back-to-back words resume at 1/cycle.
- **Collisions and no-ops:** ld_start and fetch_valid in the same cycle -> fetch not accepted, load proceeds. ld_len=0 -> no busy, no ld_done. Reset mid-load after 2 of 4 words -> IDLE next cycle, no ld_done, first 2 words readable.
- **Parity (INSTR_MEM_PARITY_EN defined):** force one RAM bit flip, then fetch that address -> parity_err = 1 and stays set until rst. With the macro undefined, parity_err stays 0.

Source files
------------

// File: rtl/instr_fetch_mem.sv
// Sequencer instruction store: streaming auto-increment loader plus a stallable fetch port.
// Optional feature: define INSTR_MEM_PARITY_EN to store and check a parity bit per word.
module instr_fetch_mem #(
  parameter int unsigned DATA_WIDTH = 60,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_start,
  input  logic [ADDR_WIDTH-1:0] ld_base,
  input  logic [ADDR_WIDTH:0]   ld_len,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  output logic                  ld_done,
  output logic                  busy,
  input  logic                  fetch_valid,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ready,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr_data,
  input  logic                  instr_ready,
  output logic                  parity_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] OneCnt   = (ADDR_WIDTH + 1)'(1);
`ifdef INSTR_MEM_PARITY_EN
  localparam int unsigned MemW = DATA_WIDTH + 1;
`else
  localparam int unsigned MemW = DATA_WIDTH;
`endif

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  logic [MemW-1:0]       mem [DEPTH];
  state_e                state_q;
  logic [ADDR_WIDTH-1:0] wp_q;
  logic [ADDR_WIDTH:0]   rc_q;
  logic                  ld_ready_q, ld_done_q, busy_q;
  logic                  instr_valid_q;
  logic [DATA_WIDTH-1:0] instr_data_q;

  logic                  start_acc, wr_en, fetch_acc;
  logic [ADDR_WIDTH:0]   len_clamped;
  logic [MemW-1:0]       wr_word, rd_word;

  assign start_acc   = (state_q == StIdle) && ld_start && (ld_len != '0);
  assign len_clamped = (ld_len > DepthCnt) ? DepthCnt : ld_len;
  // Gated by rst so an aborted load cannot sneak one more word in on the reset edge.
  assign wr_en       = ld_ready_q && ld_valid && !rst;
  // ld_start wins over a same-cycle fetch, which keeps RAM reads and writes disjoint.
  assign fetch_ready = (state_q == StIdle) && !ld_start && (!instr_valid_q || instr_ready);
  assign fetch_acc   = fetch_valid && fetch_ready;
  assign rd_word     = mem[fetch_addr];

`ifdef INSTR_MEM_PARITY_EN
  assign wr_word = {^ld_data, ld_data};
`else
  assign wr_word = ld_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wp_q       <= '0;
      rc_q       <= '0;
      ld_ready_q <= 1'b0;
      ld_done_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          ld_done_q <= 1'b0;
          if (start_acc) begin
            state_q    <= StLoad;
            wp_q       <= ld_base;
            rc_q       <= len_clamped;
            ld_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        StLoad: begin
          if (wr_en) begin
            wp_q <= wp_q + 1'b1;
            rc_q <= rc_q - OneCnt;
            if (rc_q == OneCnt) begin
              state_q    <= StDone;
              ld_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              ld_done_q  <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q   <= StIdle;
          ld_done_q <= 1'b0;
        end
        default: begin
          state_q    <= StIdle;
          ld_ready_q <= 1'b0;
          ld_done_q  <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wp_q] <= wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_valid_q <= 1'b0;
      instr_data_q  <= '0;
    end else if (fetch_acc) begin
      instr_valid_q <= 1'b1;
      instr_data_q  <= rd_word[DATA_WIDTH-1:0];
    end else if (instr_ready) begin
      instr_valid_q <= 1'b0;
    end
  end

`ifdef INSTR_MEM_PARITY_EN
  logic parity_err_q;

  // Sticky; a bad word is still delivered so the sequencer decides how to react.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else if (fetch_acc && (rd_word[DATA_WIDTH] != ^rd_word[DATA_WIDTH-1:0])) begin
      parity_err_q <= 1'b1;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign ld_ready    = ld_ready_q;
  assign ld_done     = ld_done_q;
  assign busy        = busy_q;
  assign instr_valid = instr_valid_q;
  assign instr_data  = instr_data_q;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Scoreboard bench for instr_fetch_mem: stimulus pushes expected words, a monitor pops on consume.
module tb_instr_fetch_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_start = 1'b0;
  logic [7:0]  ld_base = '0;
  logic [8:0]  ld_len = '0;
  logic        ld_valid = 1'b0;
  logic [59:0] ld_data = '0;
  logic        ld_ready, ld_done, busy;
  logic        fetch_valid = 1'b0;
  logic [7:0]  fetch_addr = '0;
  logic        fetch_ready;
  logic        instr_valid;
  logic [59:0] instr_data;
  logic        instr_ready = 1'b1;
  logic        parity_err;

  int n_checks = 0;
  int n_pass   = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  logic [59:0] exp_q[$];

  instr_fetch_mem #(
    .DATA_WIDTH(60),
    .ADDR_WIDTH(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_start   (ld_start),
    .ld_base    (ld_base),
    .ld_len     (ld_len),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .ld_done    (ld_done),
    .busy       (busy),
    .fetch_valid(fetch_valid),
    .fetch_addr (fetch_addr),
    .fetch_ready(fetch_ready),
    .instr_valid(instr_valid),
    .instr_data (instr_data),
    .instr_ready(instr_ready),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endfunction

  // Monitor: counts status pulses and scores every consumed word.
  initial begin
    logic [59:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (busy) busy_cnt++;
        if (ld_done) done_cnt++;
        if (instr_valid && instr_ready) begin
          if (exp_q.size() == 0) begin
            chk("instr_valid with empty queue", 64'(instr_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("instr_data", 64'(instr_data), 64'(e));
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the last write edge.
  task automatic do_load(input logic [7:0] base, input logic [8:0] len, input logic [59:0] first,
                         input int n_wr, input bit stall, input bit with_fetch);
    int wr = 0;
    int cyc = 0;
    busy_cnt = 0;
    done_cnt = 0;
    ld_start = 1'b1;
    ld_base  = base;
    ld_len   = len;
    if (with_fetch) begin
      fetch_valid = 1'b1;
      fetch_addr  = 8'h10;
      #1;
      chk("fetch_ready with ld_start", 64'(fetch_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    ld_start    = 1'b0;
    fetch_valid = 1'b0;
    chk("busy after start", 64'(busy), 64'd1);
    chk("ld_ready after start", 64'(ld_ready), 64'd1);
    while (wr < n_wr && cyc < 1000) begin
      ld_valid = stall ? (cyc % 2 == 0) : 1'b1;
      ld_data  = first + 60'(wr);
      if (ld_valid && ld_ready) wr++;
      @(posedge clk);
      #1;
      cyc++;
    end
    ld_valid = 1'b0;
    chk("words written", 64'(wr), 64'(n_wr));
  endtask

  task automatic finish_load(input int exp_busy);
    chk("ld_done after last write", 64'(ld_done), 64'd1);
    chk("busy in DONE", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    chk("ld_done one cycle", 64'(ld_done), 64'd0);
    chk("fetch_ready back in IDLE", 64'(fetch_ready), 64'd1);
    chk("busy cycles", 64'(busy_cnt), 64'(exp_busy));
    chk("ld_done pulses", 64'(done_cnt), 64'd1);
  endtask

  task automatic do_fetch(input logic [7:0] addr, input logic [59:0] exp, output int waited);
    fetch_valid = 1'b1;
    fetch_addr  = addr;
    waited = 0;
    #1;
    while (!fetch_ready && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (fetch_ready) exp_q.push_back(exp);
    else chk("fetch accept timeout", 64'(fetch_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("instr_valid 1 cycle after accept", 64'(instr_valid), 64'd1);
  endtask

  task automatic fetch_list(input logic [7:0] addrs[$], input logic [59:0] exps[$]);
    int w;
    for (int i = 0; i < addrs.size(); i++) begin
      do_fetch(addrs[i], exps[i], w);
      chk("back-to-back fetch stall", 64'(w), 64'd0);
    end
    fetch_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  a[$];
    logic [59:0] x[$];
    int          w;

    do_reset();
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset ld_ready", 64'(ld_ready), 64'd0);
    chk("reset ld_done", 64'(ld_done), 64'd0);
    chk("reset instr_valid", 64'(instr_valid), 64'd0);
    chk("reset instr_data", 64'(instr_data), 64'd0);
    chk("reset parity_err", 64'(parity_err), 64'd0);
    chk("reset fetch_ready", 64'(fetch_ready), 64'd1);

    // Basic load and readback.
    do_load(8'h10, 9'd4, 60'hA, 4, 1'b0, 1'b0);
    finish_load(4);
    a = '{8'h10, 8'h11, 8'h12, 8'h13};
    x = '{60'hA, 60'hB, 60'hC, 60'hD};
    fetch_list(a, x);

    // Oversized length clamps to the full depth.
    do_load(8'h00, 9'd300, 60'h100, 256, 1'b0, 1'b0);
    finish_load(256);

    // Write pointer wraps past the top of memory.
    do_load(8'hFE, 9'd3, 60'h21, 3, 1'b0, 1'b0);
    finish_load(3);
    a = '{8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01};
    x = '{60'h1FD, 60'h21, 60'h22, 60'h23, 60'h101};
    fetch_list(a, x);

    // Loader stalls on alternate cycles.
    do_load(8'h40, 9'd4, 60'h51, 4, 1'b1, 1'b0);
    finish_load(7);
    a = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44};
    x = '{60'h51, 60'h52, 60'h53, 60'h54, 60'h144};
    fetch_list(a, x);

    // Consumer stall: holding register freezes, then streaming resumes.
    instr_ready = 1'b0;
    do_fetch(8'h10, 60'h110, w);
    fetch_addr = 8'h11;
    for (int i = 0; i < 5; i++) begin
      chk("fetch_ready while held", 64'(fetch_ready), 64'd0);
      chk("instr_data held", 64'(instr_data), 64'h110);
      @(posedge clk);
      #1;
    end
    instr_ready = 1'b1;
    a = '{8'h11, 8'h12, 8'h13};
    x = '{60'h111, 60'h112, 60'h113};
    fetch_list(a, x);

    // ld_start beats a same-cycle fetch.
    do_load(8'h60, 9'd2, 60'h71, 2, 1'b0, 1'b1);
    chk("no word from blocked fetch", 64'(exp_q.size()), 64'd0);
    finish_load(2);
    a = '{8'h60, 8'h61, 8'h62};
    x = '{60'h71, 60'h72, 60'h162};
    fetch_list(a, x);

    // Zero-length start is a no-op.
    busy_cnt = 0;
    done_cnt = 0;
    ld_start = 1'b1;
    ld_len   = 9'd0;
    @(posedge clk);
    #1;
    ld_start = 1'b0;
    chk("len0 busy", 64'(busy), 64'd0);
    chk("len0 ld_ready", 64'(ld_ready), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("len0 busy cycles", 64'(busy_cnt), 64'd0);
    chk("len0 ld_done pulses", 64'(done_cnt), 64'd0);

    // Reset mid-load keeps the words already written.
    do_load(8'h80, 9'd4, 60'h91, 2, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort ld_ready", 64'(ld_ready), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort ld_done pulses", 64'(done_cnt), 64'd0);
    a = '{8'h80, 8'h81, 8'h82};
    x = '{60'h91, 60'h92, 60'h182};
    fetch_list(a, x);

`ifdef INSTR_MEM_PARITY_EN
    dut.mem[8'h60] = dut.mem[8'h60] ^ 61'd1;
    a = '{8'h60};
    x = '{60'h70};
    fetch_list(a, x);
    chk("parity_err set", 64'(parity_err), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("parity_err sticky", 64'(parity_err), 64'd1);
    do_reset();
    chk("parity_err cleared by rst", 64'(parity_err), 64'd0);
`else
    chk("parity_err tied low", 64'(parity_err), 64'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
